// File: rtl/systolic_array_pkg.sv
// Shared defaults for the weight-stationary systolic array.
// Array geometry and datapath widths used by the top and PE.
package systolic_array_pkg;
    localparam int DEF_ARRAY_ROW  = 12;
    localparam int DEF_ARRAY_COL  = 12;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 32;
endpackage

// File: rtl/systolic_array_pe.sv
// Processing element: stationary weight, activation pipeline register, signed MAC into psum.
// Latency: 1 cycle for both activation and psum.
// Backpressure: none; en_compute freezes act/psum, weight load is independent of it.
module pe
    import systolic_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_compute,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    output logic [DATA_WIDTH-1:0] act_out,
    output logic [ACC_WIDTH-1:0]  psum_out
);
    logic [DATA_WIDTH-1:0] weight_q;
    logic [ACC_WIDTH-1:0]  act_ext;
    logic [ACC_WIDTH-1:0]  weight_ext;
    logic [ACC_WIDTH-1:0]  prod;

    // Multiplying sign-extended operands modulo 2^ACC_WIDTH yields the signed
    // product already sign-extended, so the accumulate wraps naturally.
    assign act_ext    = {{(ACC_WIDTH-DATA_WIDTH){act_in[DATA_WIDTH-1]}}, act_in};
    assign weight_ext = {{(ACC_WIDTH-DATA_WIDTH){weight_q[DATA_WIDTH-1]}}, weight_q};
    assign prod       = act_ext * weight_ext;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            weight_q <= '0;
            act_out  <= '0;
            psum_out <= '0;
        end else begin
            if (load_en) begin
                weight_q <= weight_in;
            end
            if (en_compute) begin
                act_out  <= act_in;
                psum_out <= psum_in + prod;
            end
        end
    end
endmodule

// File: rtl/systolic_array.sv
// Weight-stationary systolic array: activations flow right, psums flow down, bottom row is the output.
// Latency: sample t of a skewed feed shows on column c after ARRAY_ROW+c enabled edges.
// Backpressure: none; en_compute stalls the whole array in place, positional timing only.
module systolic_array
    import systolic_array_pkg::*;
#(
    parameter int ARRAY_ROW  = DEF_ARRAY_ROW,
    parameter int ARRAY_COL  = DEF_ARRAY_COL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en_compute,
    input  logic [ARRAY_ROW-1:0]            row_load_en,
    input  logic [ARRAY_ROW*DATA_WIDTH-1:0] in_act_vec,
    input  logic [ARRAY_COL*DATA_WIDTH-1:0] in_weight_vec,
    output logic [ARRAY_COL*ACC_WIDTH-1:0]  out_psum_vec
);
    logic [DATA_WIDTH-1:0] act_q  [ARRAY_ROW][ARRAY_COL];
    logic [ACC_WIDTH-1:0]  psum_q [ARRAY_ROW][ARRAY_COL];

    for (genvar r = 0; r < ARRAY_ROW; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_COL; c++) begin : g_col
            logic [DATA_WIDTH-1:0] act_src;
            logic [ACC_WIDTH-1:0]  psum_src;

            if (c == 0) begin : g_act_edge
                assign act_src = in_act_vec[r*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_act_chain
                assign act_src = act_q[r][c-1];
            end

            if (r == 0) begin : g_psum_edge
                assign psum_src = '0;
            end else begin : g_psum_chain
                assign psum_src = psum_q[r-1][c];
            end

            pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk        (clk),
                .rst_n      (rst_n),
                .en_compute (en_compute),
                .load_en    (row_load_en[r]),
                .weight_in  (in_weight_vec[c*DATA_WIDTH +: DATA_WIDTH]),
                .act_in     (act_src),
                .psum_in    (psum_src),
                .act_out    (act_q[r][c]),
                .psum_out   (psum_q[r][c])
            );
        end
    end

    for (genvar c = 0; c < ARRAY_COL; c++) begin : g_out
        assign out_psum_vec[c*ACC_WIDTH +: ACC_WIDTH] = psum_q[ARRAY_ROW-1][c];
    end
endmodule

// File: tb/tb_systolic_array.sv
// Randomized scoreboard bench for systolic_array: every cycle each column is compared
// against sum_r in[t][r]*W[r][c], with W taken as in effect when the sample reached that PE.
module tb_systolic_array;
    localparam int R    = 12;
    localparam int C    = 12;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int MAXN = 64;
    localparam int MAXS = 160;

    logic              clk;
    logic              rst_n;
    logic              en_compute;
    logic [R-1:0]      row_load_en;
    logic [R*DW-1:0]   in_act_vec;
    logic [C*DW-1:0]   in_weight_vec;
    logic [C*AW-1:0]   out_psum_vec;

    systolic_array #(
        .ARRAY_ROW  (R),
        .ARRAY_COL  (C),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_compute    (en_compute),
        .row_load_en   (row_load_en),
        .in_act_vec    (in_act_vec),
        .in_weight_vec (in_weight_vec),
        .out_psum_vec  (out_psum_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int col;
        int val;
        int step;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: samples, current weights, and the weights in effect at each enabled edge.
    int samp  [MAXN][R];
    int nsamp;
    int s;
    int wm    [R][C];
    int wstep [MAXS][R][C];
    int tgt   [R][C];

    function automatic int act_at(input int t, input int r);
        if (t >= 0 && t < nsamp) return samp[t][r];
        return 0;
    endfunction

    // Column c after n enabled edges carries sample t = n-R-c; row r met it at edge t+r+c.
    function automatic int exp_out(input int n, input int c);
        int t;
        int sum;
        t   = n - R - c;
        sum = 0;
        if (t >= 0 && t < nsamp) begin
            for (int r = 0; r < R; r++) sum += samp[t][r] * wstep[t+r+c][r][c];
        end
        return sum;
    endfunction

    task automatic push_all(input int forced_zero);
        exp_t e;
        for (int c = 0; c < C; c++) begin
            e.col  = c;
            e.val  = forced_zero ? 0 : exp_out(s, c);
            e.step = s;
            sb_q.push_back(e);
        end
    endtask

    task automatic cycle(input bit en, input logic [R-1:0] ld, input logic [C*DW-1:0] wv);
        for (int r = 0; r < R; r++) in_act_vec[r*DW +: DW] = DW'(act_at(s - r, r));
        en_compute    = en;
        row_load_en   = ld;
        in_weight_vec = wv;
        @(posedge clk);
        #1;
        if (en) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) wstep[s][r][c] = wm[r][c];
            s++;
        end
        for (int r = 0; r < R; r++)
            if (ld[r])
                for (int c = 0; c < C; c++) wm[r][c] = int'($signed(wv[c*DW +: DW]));
        push_all(0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en_compute  = 1'b1;
            row_load_en = '1;
            for (int r = 0; r < R; r++) in_act_vec[r*DW +: DW] = DW'($urandom_range(1, 255));
            for (int c = 0; c < C; c++) in_weight_vec[c*DW +: DW] = DW'($urandom_range(1, 255));
            @(posedge clk);
            #1;
            push_all(1);
        end
        rst_n       = 1'b0;
        en_compute  = 1'b0;
        row_load_en = '0;
        s           = 0;
        nsamp       = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) wm[r][c] = 0;
    endtask

    task automatic load_tgt();
        logic [C*DW-1:0] wv;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) wv[c*DW +: DW] = DW'(tgt[r][c]);
            cycle(1'b0, R'(1) << r, wv);
        end
    endtask

    task automatic rand_weights();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) tgt[r][c] = int'($signed(DW'($urandom)));
        load_tgt();
    endtask

    task automatic rand_samples(input int n);
        nsamp = n;
        for (int t = 0; t < n; t++)
            for (int r = 0; r < R; r++) samp[t][r] = int'($signed(DW'($urandom)));
    endtask

    task automatic const_samples(input int n, input int v);
        nsamp = n;
        for (int t = 0; t < n; t++)
            for (int r = 0; r < R; r++) samp[t][r] = v;
    endtask

    task automatic const_weights(input int v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) tgt[r][c] = v;
        load_tgt();
    endtask

    task automatic stream(input int len, input int stall_at, input int reload_at);
        logic [C*DW-1:0] twos;
        for (int c = 0; c < C; c++) twos[c*DW +: DW] = DW'(2);
        for (int k = 0; k < len; k++) begin
            if (k == stall_at) repeat (3) cycle(1'b0, '0, '0);
            cycle(1'b1, (k == reload_at) ? R'(1) : R'(0), twos);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [AW-1:0] got;
            e   = sb_q.pop_front();
            got = out_psum_vec[e.col*AW +: AW];
            n_tests++;
            if (got !== AW'(e.val)) begin
                n_fail++;
                $display("FAIL psum col%0d step%0d: got %0d, expected %0d",
                         e.col, e.step, $signed(got), e.val);
            end
        end
    end

    initial begin
        rst_n         = 1'b1;
        en_compute    = 1'b0;
        row_load_en   = '0;
        in_act_vec    = '0;
        in_weight_vec = '0;
        s             = 0;
        nsamp         = 0;

        do_reset();

        // Identity weights: column c of sample t must read t+c.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) tgt[r][c] = (r == c) ? 1 : 0;
        load_tgt();
        nsamp = 16;
        for (int t = 0; t < nsamp; t++)
            for (int r = 0; r < R; r++) samp[t][r] = t + r;
        stream(nsamp + R + C, -1, -1);

        // Signed extremes.
        do_reset();
        const_weights(-128);
        const_samples(3, -128);
        stream(nsamp + R + C, -1, -1);
        do_reset();
        const_weights(127);
        const_samples(3, -128);
        stream(nsamp + R + C, -1, -1);

        // Random regression.
        do_reset();
        rand_weights();
        rand_samples(32);
        stream(nsamp + R + C, -1, -1);

        // Stall mid-stream.
        do_reset();
        rand_weights();
        rand_samples(32);
        stream(nsamp + R + C, 20, -1);

        // Row 0 reload while streaming.
        do_reset();
        rand_weights();
        rand_samples(32);
        stream(nsamp + R + C, -1, 18);

        // Reset with data in flight, then idle compute must stay at zero.
        do_reset();
        rand_weights();
        rand_samples(32);
        stream(20, -1, -1);
        do_reset();
        stream(5, -1, -1);

        repeat (2) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
